// File: rtl/instr_fetch_pkg.sv
// ============================================================
// Module : instr_fetch_pkg
// Brief  : Opcodes, FSM states and instruction field positions.
// Rev    : 1.0
// ============================================================
`default_nettype none

package instr_fetch_pkg;

  localparam int c_OPC_LSB = 0;
  localparam int c_OPC_MSB = 5;
  localparam int c_A1_LSB  = 6;
  localparam int c_A1_MSB  = 10;
  localparam int c_A2_LSB  = 11;
  localparam int c_A2_MSB  = 15;
  localparam int c_A3_LSB  = 16;
  localparam int c_A3_MSB  = 20;

  localparam logic [5:0] c_OP_ADD = 6'd1;
  localparam logic [5:0] c_OP_XOR = 6'd2;
  localparam logic [5:0] c_OP_OR  = 6'd3;
  localparam logic [5:0] c_OP_MIN = 6'd4;
  localparam logic [5:0] c_OP_AND = 6'd5;
  localparam logic [5:0] c_OP_SUB = 6'd6;
  localparam logic [5:0] c_OP_MAX = 6'd7;
  localparam logic [5:0] c_OP_NEG = 6'd8;
  localparam logic [5:0] c_OP_AVG = 6'd11;
  localparam logic [5:0] c_OP_ABS = 6'd13;
  localparam logic [5:0] c_OP_NOT = 6'd15;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  function automatic logic op_is_valid(input logic [5:0] op);
    case (op)
      c_OP_ADD, c_OP_XOR, c_OP_OR, c_OP_MIN, c_OP_AND, c_OP_SUB,
      c_OP_MAX, c_OP_NEG, c_OP_AVG, c_OP_ABS, c_OP_NOT: op_is_valid = 1'b1;
      default:                                           op_is_valid = 1'b0;
    endcase
  endfunction

  // Unary operations read only addr1.
  function automatic logic op_uses_src2(input logic [5:0] op);
    op_uses_src2 = op_is_valid(op) &&
                   !(op == c_OP_NEG || op == c_OP_ABS || op == c_OP_NOT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fetch_hazard_check.sv
// ============================================================
// Module : instr_fetch_hazard_check
// Brief  : Recent-destination history and source-operand compare.
// Rev    : 1.0
// ============================================================
`default_nettype none

module instr_fetch_hazard_check #(
  parameter int HAZARD_WINDOW = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       shift,
  input  logic       push_valid,
  input  logic [4:0] push_addr,
  input  logic [4:0] src1,
  input  logic [4:0] src2,
  input  logic       use_src2,
  output logic       hazard
);

  logic [HAZARD_WINDOW-1:0] r_vld;
  logic [4:0]               r_addr [HAZARD_WINDOW];
  logic [HAZARD_WINDOW-1:0] w_hit;

  // Entry 0 is the most recently issued slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < HAZARD_WINDOW; i++) r_addr[i] <= '0;
    end else if (clear) begin
      r_vld <= '0;
    end else if (shift) begin
      for (int i = HAZARD_WINDOW - 1; i > 0; i--) begin
        r_vld[i]  <= r_vld[i-1];
        r_addr[i] <= r_addr[i-1];
      end
      r_vld[0]  <= push_valid;
      r_addr[0] <= push_addr;
    end
  end

  generate
    for (genvar i = 0; i < HAZARD_WINDOW; i++) begin : g_cmp
      assign w_hit[i] = r_vld[i] &&
                        ((r_addr[i] == src1) || (use_src2 && (r_addr[i] == src2)));
    end
  endgenerate

  assign hazard = |w_hit;

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================
// Module : instr_fetch
// Brief  : Program memory, fetch FSM and hazard-bubble issue.
// Rev    : 1.0
// ============================================================
`default_nettype none

module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH         = 32,
  parameter int HAZARD_WINDOW = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_en,
  input  logic [4:0]  load_addr,
  input  logic [31:0] load_data,
  input  logic        start,
  input  logic [4:0]  prog_len,
  output logic [31:0] instruction,
  output logic        issue_valid,
  output logic [4:0]  pc,
  output logic        busy,
  output logic        done
);

  localparam int              c_CW         = $clog2(HAZARD_WINDOW + 1);
  localparam logic [c_CW-1:0] c_DRAIN_LAST = c_CW'(HAZARD_WINDOW);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_mem [DEPTH];
  logic [4:0]        r_prog_len;
  logic [c_CW-1:0]   r_drain_cnt;

  logic [31:0] w_fetch;
  logic [5:0]  w_opc;
  logic        w_op_ok;
  logic        w_use_src2;
  logic        w_hazard;
  logic        w_start_acc;
  logic        w_last;
  logic [31:0] w_issue;
  logic        w_issue_vld;
  logic        w_adv;
  logic        w_push_vld;
  logic        w_shift;
  logic        w_clear;

  assign w_fetch     = r_mem[pc];
  assign w_opc       = w_fetch[c_OPC_MSB:c_OPC_LSB];
  assign w_op_ok     = op_is_valid(w_opc);
  assign w_use_src2  = op_uses_src2(w_opc);
  assign w_start_acc = (r_state == S_IDLE) && start;
  assign w_last      = (pc == r_prog_len);
  assign busy        = (r_state != S_IDLE);

  // Loads only while idle; a simultaneous start takes priority.
  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && load_en && !start)
      r_mem[load_addr] <= load_data;
  end

  instr_fetch_hazard_check #(
    .HAZARD_WINDOW (HAZARD_WINDOW)
  ) u_hazard (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (w_clear),
    .shift      (w_shift),
    .push_valid (w_push_vld),
    .push_addr  (w_fetch[c_A3_MSB:c_A3_LSB]),
    .src1       (w_fetch[c_A1_MSB:c_A1_LSB]),
    .src2       (w_fetch[c_A2_MSB:c_A2_LSB]),
    .use_src2   (w_use_src2),
    .hazard     (w_hazard)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_adv && w_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_drain_cnt == c_DRAIN_LAST) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Illegal opcodes are skipped as bubbles and never become producers.
  always_comb begin
    w_issue     = '0;
    w_issue_vld = 1'b0;
    w_adv       = 1'b0;
    w_push_vld  = 1'b0;
    w_shift     = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE: w_clear = start;
      S_RUN: begin
        w_shift = 1'b1;
        if (!w_op_ok) begin
          w_adv = 1'b1;
        end else if (!w_hazard) begin
          w_adv       = 1'b1;
          w_issue     = w_fetch;
          w_issue_vld = 1'b1;
          w_push_vld  = 1'b1;
        end
      end
      S_DRAIN: w_shift = 1'b1;
      default: ;
    endcase
  end

  // pc parks on the last index so prog_len=31 never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instruction <= '0;
      issue_valid <= 1'b0;
      pc          <= '0;
      done        <= 1'b0;
      r_prog_len  <= '0;
      r_drain_cnt <= '0;
    end else begin
      instruction <= w_issue;
      issue_valid <= w_issue_vld;
      done        <= (r_state == S_DRAIN) && (w_state_nxt == S_IDLE);
      r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + 1'b1 : '0;
      if (w_start_acc) begin
        r_prog_len <= prog_len;
        pc         <= '0;
      end else if (w_adv && !w_last) begin
        pc <= pc + 5'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================
// Module : tb_instr_fetch
// Brief  : Scoreboard bench for instr_fetch.
// Rev    : 1.0
// ============================================================
`default_nettype none

module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_en = 1'b0;
  logic [4:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        start = 1'b0;
  logic [4:0]  prog_len = '0;
  logic [31:0] instruction;
  logic        issue_valid;
  logic [4:0]  pc;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic        vld;
    logic        dn;
    logic [4:0]  pc;
  } obs_t;

  obs_t exp_q[$];

  instr_fetch #(
    .DEPTH         (32),
    .HAZARD_WINDOW (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .start       (start),
    .prog_len    (prog_len),
    .instruction (instruction),
    .issue_valid (issue_valid),
    .pc          (pc),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic void push(input logic [31:0] i, input logic v, input logic d,
                               input logic [4:0] p);
    obs_t o;
    o.instr = i; o.vld = v; o.dn = d; o.pc = p;
    exp_q.push_back(o);
  endfunction

  function automatic logic [31:0] indep_word(input int k);
    logic [31:0] w;
    w = 32'h0001_0008 | (32'(k) << 21);
    return w;
  endfunction

  task automatic load(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic kick(input logic [4:0] len);
    @(negedge clk);
    start = 1'b1; prog_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int  k = 0;
    bit  seen = 1'b0;
    while (k < 200 && !seen) begin
      @(posedge clk); #1;
      seen = done;
      k++;
    end
    chk(name, {31'd0, seen}, 32'd1);
    @(negedge clk);
  endtask

  // Every busy/done cycle must match the next expected observation.
  initial begin
    obs_t got, e;
    forever begin
      @(posedge clk); #1;
      if (rst_n && (busy || done)) begin
        got.instr = instruction; got.vld = issue_valid; got.dn = done; got.pc = pc;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output instr=%h vld=%b done=%b pc=%0d, expected nothing",
                   got.instr, got.vld, got.dn, got.pc);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_fail++;
            $display("FAIL stream got instr=%h vld=%b done=%b pc=%0d, expected instr=%h vld=%b done=%b pc=%0d",
                     got.instr, got.vld, got.dn, got.pc, e.instr, e.vld, e.dn, e.pc);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired, simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push_invalid_then_add();
    push(32'h0, 1'b0, 1'b0, 5'd0);
    push(32'h0, 1'b0, 1'b0, 5'd1);
    push(32'h001F_1041, 1'b1, 1'b0, 5'd1);
    push(32'h0, 1'b0, 1'b0, 5'd1);
    push(32'h0, 1'b0, 1'b0, 5'd1);
    push(32'h0, 1'b0, 1'b1, 5'd1);
  endtask

  initial begin
    // Reset state
    @(posedge clk); #1;
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_issue_valid", {31'd0, issue_valid}, 32'd0);
    chk("rst_pc", {27'd0, pc}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // RAW hazard on r31: two bubbles between producer and consumer
    load(5'd0, 32'h001F_1041);
    load(5'd1, 32'h001F_F886);
    push(32'h0, 1'b0, 1'b0, 5'd0);
    push(32'h001F_1041, 1'b1, 1'b0, 5'd1);
    push(32'h0, 1'b0, 1'b0, 5'd1);
    push(32'h0, 1'b0, 1'b0, 5'd1);
    push(32'h001F_F886, 1'b1, 1'b0, 5'd1);
    push(32'h0, 1'b0, 1'b0, 5'd1);
    push(32'h0, 1'b0, 1'b0, 5'd1);
    push(32'h0, 1'b0, 1'b1, 5'd1);
    kick(5'd1);
    wait_done("done_raw");

    // Independent ABS then NEG issue back to back
    load(5'd0, 32'h000E_03CD);
    load(5'd1, 32'h0013_00C8);
    push(32'h0, 1'b0, 1'b0, 5'd0);
    push(32'h000E_03CD, 1'b1, 1'b0, 5'd1);
    push(32'h0013_00C8, 1'b1, 1'b0, 5'd1);
    push(32'h0, 1'b0, 1'b0, 5'd1);
    push(32'h0, 1'b0, 1'b0, 5'd1);
    push(32'h0, 1'b0, 1'b1, 5'd1);
    kick(5'd1);
    wait_done("done_indep");

    // ABS ignores its addr2 field (19), which matches NEG's destination
    load(5'd0, 32'h0013_00C8);
    load(5'd1, 32'h0000_9BCD);
    push(32'h0, 1'b0, 1'b0, 5'd0);
    push(32'h0013_00C8, 1'b1, 1'b0, 5'd1);
    push(32'h0000_9BCD, 1'b1, 1'b0, 5'd1);
    push(32'h0, 1'b0, 1'b0, 5'd1);
    push(32'h0, 1'b0, 1'b0, 5'd1);
    push(32'h0, 1'b0, 1'b1, 5'd1);
    kick(5'd1);
    wait_done("done_abs");

    // Illegal opcode 9 is skipped as a bubble
    load(5'd0, 32'h0000_0009);
    load(5'd1, 32'h001F_1041);
    push_invalid_then_add();
    kick(5'd1);
    wait_done("done_illegal");

    // start+load together, then start/load pulsed while busy: all loads dropped
    push_invalid_then_add();
    @(negedge clk);
    start = 1'b1; prog_len = 5'd1;
    load_en = 1'b1; load_addr = 5'd0; load_data = 32'h001F_1041;
    @(negedge clk);
    start = 1'b1; prog_len = 5'd0;
    load_en = 1'b1; load_addr = 5'd1; load_data = 32'h0;
    @(negedge clk);
    start = 1'b0; load_en = 1'b0;
    wait_done("done_busy_ignore");

    // Memory retained across runs and unchanged by the ignored loads
    push_invalid_then_add();
    kick(5'd1);
    wait_done("done_retain");

    // Asynchronous reset mid-run at pc=5 aborts with no done
    for (int k = 0; k <= 10; k++) load(5'(k), indep_word(k));
    push(32'h0, 1'b0, 1'b0, 5'd0);
    for (int k = 1; k <= 5; k++) push(indep_word(k - 1), 1'b1, 1'b0, 5'(k));
    kick(5'd10);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_instruction", instruction, 32'h0);
    chk("abort_issue_valid", {31'd0, issue_valid}, 32'd0);
    chk("abort_pc", {27'd0, pc}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_queue_drained", 32'(exp_q.size()), 32'd0);

    // prog_len=31 runs all 32 entries and pc parks at 31
    for (int k = 0; k < 32; k++) load(5'(k), indep_word(k));
    push(32'h0, 1'b0, 1'b0, 5'd0);
    for (int k = 1; k <= 31; k++) push(indep_word(k - 1), 1'b1, 1'b0, 5'(k));
    push(indep_word(31), 1'b1, 1'b0, 5'd31);
    push(32'h0, 1'b0, 1'b0, 5'd31);
    push(32'h0, 1'b0, 1'b0, 5'd31);
    push(32'h0, 1'b0, 1'b1, 5'd31);
    kick(5'd31);
    wait_done("done_full");

    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
